// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display:
// segment patterns, cathode bit order, conversion FSM states and pow10.
package seg_pkg;

    // Cathode bit order: cathode[6]=a, [5]=b, [4]=c, [3]=d, [2]=e, [1]=f, [0]=g.
    // All patterns are active-low (0 = segment lit).
    localparam int SEG_W = 7;
    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_DASH  = 7'b1111110;

    localparam logic [SEG_W-1:0] SEG_DIGIT [0:9] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100   // 9
    };

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_e;

    // Elaboration-time power of ten.
    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    // BCD nibble to active-low segments; non-decimal codes go dark.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] v);
        if (v > 4'd9) return SEG_BLANK;
        return SEG_DIGIT[v];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with change detect.
// A conversion starts whenever the input differs from the last converted
// value; the committed BCD and overflow flag only update as a whole.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   CONV_IDLE  | waiting; compares bin_i against last converted value
//   CONV_SHIFT | one add-3 / shift step per edge, BIN_W steps total
//   CONV_DONE  | commit scratch BCD and overflow flag, drop busy
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W  = 7,
    parameter int DIGITS = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o,
    output logic                  busy_o
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam longint unsigned P10 = pow10(DIGITS);
    localparam longint unsigned CAP = 64'd1 << BIN_W;
    // When 10^DIGITS does not fit in BIN_W bits, clamp to 2^BIN_W so the
    // comparison can never be true.
    localparam logic [BIN_W:0] LIMIT = (BIN_W+1)'((P10 < CAP) ? P10 : CAP);

    conv_state_e          state_q;
    logic [BIN_W-1:0]     last_q;
    logic [BIN_W-1:0]     shreg_q;
    logic [BCD_W-1:0]     scratch_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BCD_W-1:0]     bcd_q;
    logic                 ovf_q;
    logic                 busy_q;

    logic [BCD_W-1:0]       adj_d;
    logic [BCD_W+BIN_W-1:0] shift_d;

    // Add-3 correction on every nibble >= 5, then the combined left shift.
    always_comb begin
        adj_d = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        shift_d = {adj_d, shreg_q} << 1;
    end

    // Conversion FSM with registered busy/bcd/ovf outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= CONV_IDLE;
            last_q    <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                CONV_IDLE: begin
                    if (bin_i != last_q) begin
                        last_q    <= bin_i;
                        shreg_q   <= bin_i;
                        scratch_q <= '0;
                        cnt_q     <= CNT_W'(BIN_W);
                        busy_q    <= 1'b1;
                        state_q   <= CONV_SHIFT;
                    end
                end
                CONV_SHIFT: begin
                    scratch_q <= shift_d[BCD_W+BIN_W-1 -: BCD_W];
                    shreg_q   <= shift_d[BIN_W-1:0];
                    cnt_q     <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_q <= CONV_DONE;
                end
                CONV_DONE: begin
                    bcd_q   <= scratch_q;
                    ovf_q   <= ({1'b0, last_q} >= LIMIT);
                    busy_q  <= 1'b0;
                    state_q <= CONV_IDLE;
                end
                default: state_q <= CONV_IDLE;
            endcase
        end
    end

    assign bcd_o  = bcd_q;
    assign ovf_o  = ovf_q;
    assign busy_o = busy_q;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner: score (via sequential BCD conversion)
// on the leftmost SCORE_DIGITS positions, live BCD timer digits on the rest.
// Optional build macro SEG_LEAD_ZERO_BLANK_EN blanks leading zero score
// digits (rightmost score digit always shown, dashes take priority).
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCORE_DIGITS = 2,
    parameter int BIN_W        = 7
) (
    input  logic                                     digit_clk,
    input  logic                                     rst_n,
    input  logic [BIN_W-1:0]                         score_bin,
    input  logic [4*(NUM_DIGITS-SCORE_DIGITS)-1:0]   sec_bcd,
    input  logic                                     blank,
    output logic [NUM_DIGITS-1:0]                    anode,
    output logic [SEG_W-1:0]                         cathode,
    output logic                                     conv_busy
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int SBCD_W = 4 * SCORE_DIGITS;

    logic [SBCD_W-1:0]     score_bcd;
    logic                  score_ovf;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [SEG_W-1:0]      cathode_q, cathode_d;
    logic [SEG_W-1:0]      pos_seg [NUM_DIGITS];

    bin2bcd_seq #(
        .BIN_W  (BIN_W),
        .DIGITS (SCORE_DIGITS)
    ) u_conv (
        .clk_i   (digit_clk),
        .rst_n_i (rst_n),
        .bin_i   (score_bin),
        .bcd_o   (score_bcd),
        .ovf_o   (score_ovf),
        .busy_o  (conv_busy)
    );

    // Segment pattern for each score position, most significant first.
    for (genvar k = 0; k < SCORE_DIGITS; k++) begin : g_score
        logic [3:0] nib;
        assign nib = score_bcd[4*(SCORE_DIGITS-1-k) +: 4];
`ifdef SEG_LEAD_ZERO_BLANK_EN
        logic lead_zero;
        assign lead_zero = (k < SCORE_DIGITS-1) && (score_bcd[SBCD_W-1 -: 4*(k+1)] == '0);
        assign pos_seg[k] = score_ovf ? SEG_DASH : (lead_zero ? SEG_BLANK : seg_decode(nib));
`else
        assign pos_seg[k] = score_ovf ? SEG_DASH : seg_decode(nib);
`endif
    end

    // Segment pattern for each timer position, straight from the live input.
    for (genvar k = SCORE_DIGITS; k < NUM_DIGITS; k++) begin : g_time
        assign pos_seg[k] = seg_decode(sec_bcd[4*(NUM_DIGITS-1-k) +: 4]);
    end

    // Select the current position's anode/cathode; blank forces everything dark.
    always_comb begin
        anode_d   = '1;
        cathode_d = SEG_BLANK;
        idx_d     = (idx_q == IDX_W'(NUM_DIGITS-1)) ? '0 : idx_q + 1'b1;
        if (!blank) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (idx_q == IDX_W'(k)) begin
                    anode_d[NUM_DIGITS-1-k] = 1'b0;
                    cathode_d               = pos_seg[k];
                end
            end
        end
    end

    // Scan index always advances so blanking never slips the phase.
    always_ff @(posedge digit_clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            anode_q   <= '1;
            cathode_q <= SEG_BLANK;
        end else begin
            idx_q     <= idx_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
        end
    end

    assign anode   = anode_q;
    assign cathode = cathode_q;

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

    localparam int N  = 4;
    localparam int SD = 2;
    localparam int BW = 7;
    localparam int TD = N - SD;

    logic            digit_clk;
    logic            rst_n;
    logic [BW-1:0]   score_bin;
    logic [4*TD-1:0] sec_bcd;
    logic            blank;
    logic [N-1:0]    anode;
    logic [6:0]      cathode;
    logic            conv_busy;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    seg_scan_display #(
        .NUM_DIGITS   (N),
        .SCORE_DIGITS (SD),
        .BIN_W        (BW)
    ) dut (
        .digit_clk (digit_clk),
        .rst_n     (rst_n),
        .score_bin (score_bin),
        .sec_bcd   (sec_bcd),
        .blank     (blank),
        .anode     (anode),
        .cathode   (cathode),
        .conv_busy (conv_busy)
    );

    initial digit_clk = 1'b0;
    always #5 digit_clk = ~digit_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    int m_idx = 0, m_commit = 0, m_last = 0, m_phase = 0;
    logic [N-1:0] exp_an   = '1;
    logic [6:0]   exp_cath = '1;
    logic         exp_busy = 1'b0;
    int cyc = 0;

    function automatic logic [6:0] model_pos(input int k, input int committed, input logic [4*TD-1:0] sec);
        int w;
        if (k < SD) begin
            if (committed >= 10**SD) return 7'b1111110;
            w = 10**(SD-1-k);
`ifdef SEG_LEAD_ZERO_BLANK_EN
            if (k < SD-1 && committed < w) return 7'b1111111;
`endif
            return seg_of((committed / w) % 10);
        end
        return seg_of(int'(sec >> (4*(N-1-k))) & 15);
    endfunction

    // Outputs expected after each edge, from the state before that edge.
    always @(posedge digit_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idx = 0; m_commit = 0; m_last = 0; m_phase = 0; cyc = 0;
            exp_an = '1; exp_cath = '1; exp_busy = 1'b0;
        end else begin
            cyc++;
            exp_an = '1;
            exp_cath = '1;
            if (!blank) begin
                exp_an[N-1-m_idx] = 1'b0;
                exp_cath = model_pos(m_idx, m_commit, sec_bcd);
            end
            if (m_phase == 0) begin
                if (int'(score_bin) != m_last) begin
                    m_last = int'(score_bin);
                    m_phase = BW + 1;
                    exp_busy = 1'b1;
                end
            end else begin
                m_phase--;
                if (m_phase == 0) begin
                    m_commit = m_last;
                    exp_busy = 1'b0;
                end
            end
            m_idx = (m_idx + 1) % N;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge digit_clk) begin
        if (chk_en) begin
            chk("anode", 32'(anode), 32'(exp_an));
            chk("cathode", 32'(cathode), 32'(exp_cath));
            chk("conv_busy", 32'(conv_busy), 32'(exp_busy));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic check_scan(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] got [N];
        bit         seen [N];
        logic [6:0] e [N];
        int         zeros;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < N; i++) begin got[i] = '1; seen[i] = 0; end
        for (int c = 0; c < N; c++) begin
            @(negedge digit_clk);
            zeros = 0;
            for (int b = 0; b < N; b++) begin
                if (anode[b] === 1'b0) begin
                    zeros++;
                    got[N-1-b] = cathode;
                    seen[N-1-b] = 1;
                end
            end
            chk({tag, "_onehot"}, 32'(zeros), 32'd1);
        end
        for (int i = 0; i < N; i++) chk($sformatf("%s_pos%0d", tag, i), {24'd0, seen[i], got[i]}, {24'd0, 1'b1, e[i]});
    endtask

    task automatic count_busy(input int n, output int cnt);
        cnt = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge digit_clk);
            if (conv_busy === 1'b1) cnt++;
        end
    endtask

    int bcnt;

    initial begin
        score_bin = '0; sec_bcd = '0; blank = 1'b0; rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_en = 1;
        repeat (3) @(negedge digit_clk);
        chk("reset_anode", 32'(anode), 32'hF);
        chk("reset_cathode", 32'(cathode), 32'h7F);
        chk("reset_busy", 32'(conv_busy), 32'd0);
        rst_n = 1'b1;

        // zero score: anode walks 0111,1011,1101,1110
        @(negedge digit_clk);
        chk("first_anode", 32'(anode), 32'b0111);
        @(negedge digit_clk);
        chk("second_anode", 32'(anode), 32'b1011);
        check_scan("zero", 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);
        count_busy(10, bcnt);
        chk("zero_busy", 32'(bcnt), 32'd0);

        // 42 with timer 59
        score_bin = 7'd42; sec_bcd = 8'h59;
        count_busy(12, bcnt);
        chk("busy_len_42", 32'(bcnt), 32'd8);
        check_scan("s42", 7'b1001100, 7'b0010010, 7'b0100100, 7'b0000100);

        // overflow
        score_bin = 7'd100;
        repeat (12) @(negedge digit_clk);
        check_scan("ovf", 7'b1111110, 7'b1111110, 7'b0100100, 7'b0000100);

        // change during SHIFT: 42 completes, 43 follows
        score_bin = 7'd42;
        repeat (3) @(negedge digit_clk);
        score_bin = 7'd43;
        repeat (25) @(negedge digit_clk);
        check_scan("s43", 7'b1001100, 7'b0000110, 7'b0100100, 7'b0000100);

        // blank for 3 edges, phase preserved
        blank = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge digit_clk);
            chk("blank_anode", 32'(anode), 32'hF);
            chk("blank_cathode", 32'(cathode), 32'h7F);
        end
        blank = 1'b0;
        @(negedge digit_clk);
        chk("blank_phase", 32'(anode), 32'(~(4'b0001 << (N-1-((cyc-1) % N)))) & 32'hF);

        // reset pulse during SHIFT
        score_bin = 7'd10;
        repeat (3) @(negedge digit_clk);
        score_bin = 7'd42;
        #2 rst_n = 1'b0;
        #1;
        chk("async_anode", 32'(anode), 32'hF);
        chk("async_cathode", 32'(cathode), 32'h7F);
        chk("async_busy", 32'(conv_busy), 32'd0);
        @(negedge digit_clk);
        rst_n = 1'b1;
        count_busy(12, bcnt);
        chk("busy_len_rst", 32'(bcnt), 32'd8);
        check_scan("rst42", 7'b1001100, 7'b0010010, 7'b0100100, 7'b0000100);

        // single-digit score
        score_bin = 7'd7;
        repeat (12) @(negedge digit_clk);
`ifdef SEG_LEAD_ZERO_BLANK_EN
        check_scan("s7", 7'b1111111, 7'b0001111, 7'b0100100, 7'b0000100);
`else
        check_scan("s7", 7'b0000001, 7'b0001111, 7'b0100100, 7'b0000100);
`endif

        // randomized traffic against the model
        for (int it = 0; it < 1500; it++) begin
            if ($urandom_range(0, 5) == 0) score_bin = BW'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) sec_bcd = 8'($urandom);
            blank = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_async_anode", 32'(anode), 32'hF);
                chk("rnd_async_busy", 32'(conv_busy), 32'd0);
                @(negedge digit_clk);
                rst_n = 1'b1;
            end
            @(negedge digit_clk);
        end
        blank = 1'b0;
        repeat (20) @(negedge digit_clk);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
